regfile_wport_arbiter: RTL

//  Shares the single register-file write port between pipeline writeback (port 0) and the

---
 rtl/regfile_wport_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/regfile_wport_arbiter.sv
// rtl/regfile_wport_arbiter.sv - arbitrates the register-file write port between writeback and MULT/DIV results
// Optional pending-write forwarding hit detection is enabled with PEND_FWD_EN.
module regfile_wport_arbiter #(
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              P0_valid,
  input  logic [4:0]        P0_addr,
  input  logic [DATA_W-1:0] P0_data,
  output logic              P0_ready,
  input  logic              P1_valid,
  input  logic [4:0]        P1_addr,
  input  logic [DATA_W-1:0] P1_data,
  output logic              P1_ready,
  output logic              Wr_en,
  output logic              Wr_sel,
  output logic [4:0]        Wr_addr,
  output logic [DATA_W-1:0] Wr_data,
`ifdef PEND_FWD_EN
  input  logic [4:0]        Rd_addr_a,
  input  logic [4:0]        Rd_addr_b,
`endif
  output logic [1:0]        Fwd_hit
);

  typedef enum logic [1:0] {IDLE, HELD, FORCE} state_t;

  localparam logic [2:0] WAIT_LAST = 3'(MAX_WAIT - 1);

  state_t              state, state_nxt;
  logic [4:0]          buf_addr;
  logic [DATA_W-1:0]   buf_data;
  logic [2:0]          wait_cnt;
  logic                buf_valid;
  logic                p0_acc, p1_load, p0_write, grant_buf, buf_lost;

  assign buf_valid = (state != IDLE);
  assign P0_ready  = (state != FORCE);
  assign P1_ready  = ~buf_valid;

  assign p0_acc    = P0_valid & P0_ready;
  assign p1_load   = P1_valid & P1_ready & (|P1_addr);
  assign p0_write  = p0_acc & (|P0_addr);
  assign grant_buf = (state == FORCE) | (buf_valid & ~p0_acc);
  assign buf_lost  = (state == HELD) & p0_acc;

  // A port-1 load is only possible from IDLE, so HELD never sees a reload on grant.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (p1_load) state_nxt = HELD;
      HELD: begin
        if (grant_buf)                 state_nxt = IDLE;
        else if (wait_cnt >= WAIT_LAST) state_nxt = FORCE;
      end
      FORCE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= 3'd0;
      buf_addr <= 5'd0;
      buf_data <= '0;
    end else begin
      state <= state_nxt;
      if (grant_buf)
        wait_cnt <= 3'd0;
      else if (buf_lost && wait_cnt != 3'd7)
        wait_cnt <= wait_cnt + 3'd1;
      if (p1_load) begin
        buf_addr <= P1_addr;
        buf_data <= P1_data;
      end
    end
  end

  // Select, address and data hold their last values when nothing is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Wr_en   <= 1'b0;
      Wr_sel  <= 1'b0;
      Wr_addr <= 5'd0;
      Wr_data <= '0;
    end else begin
      Wr_en <= p0_write | grant_buf;
      if (grant_buf) begin
        Wr_sel  <= 1'b1;
        Wr_addr <= buf_addr;
        Wr_data <= buf_data;
      end else if (p0_write) begin
        Wr_sel  <= 1'b0;
        Wr_addr <= P0_addr;
        Wr_data <= P0_data;
      end
    end
  end

`ifdef PEND_FWD_EN
  assign Fwd_hit[0] = buf_valid & (buf_addr == Rd_addr_a) & (|Rd_addr_a);
  assign Fwd_hit[1] = buf_valid & (buf_addr == Rd_addr_b) & (|Rd_addr_b);
`else
  assign Fwd_hit = 2'b00;
`endif

endmodule
